// File: rtl/display_seq_pkg.sv
// Shared types and constants for the parking-lot display sequencer.
package display_seq_pkg;

   typedef enum logic [1:0] {
      OFF   = 2'd0,
      ON    = 2'd1,
      PAY   = 2'd2,
      DELAY = 2'd3
   } disp_state_t;

   localparam int DIGITS = 8;
   localparam int SCAN_W = 3;

   // Counter width for a modulus of v, never narrower than one bit.
   function automatic int clog2_min1(input int v);
      return (v < 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Digit scan prescaler: divides clk into digit slots and strobes the last
// cycle of digit 7. Held at zero while run is low.
module scan_prescaler
   import display_seq_pkg::*;
#(
   parameter int SCAN_DIV = 50000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   output logic [SCAN_W-1:0] scan_cnt,
   output logic              frame_tick
);

   localparam int PRE_W = $clog2(SCAN_DIV);
   localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(SCAN_DIV - 1);
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(DIGITS - 1);

   logic [PRE_W-1:0]  pre_q, pre_d;
   logic [SCAN_W-1:0] scan_q, scan_d;
   logic              pre_wrap;

   assign pre_wrap = (pre_q == PRE_LAST);

   always_comb begin
      pre_d  = pre_q;
      scan_d = scan_q;
      if (!run) begin
         pre_d  = '0;
         scan_d = '0;
      end else if (pre_wrap) begin
         pre_d  = '0;
         scan_d = scan_q + SCAN_W'(1);
      end else begin
         pre_d  = pre_q + PRE_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pre_q  <= '0;
         scan_q <= '0;
      end else begin
         pre_q  <= pre_d;
         scan_q <= scan_d;
      end
   end

   // Counters sit at zero while idle, so the strobe cannot fire in OFF.
   assign frame_tick = pre_wrap && (scan_q == SCAN_LAST);
   assign scan_cnt   = scan_q;

endmodule

// File: rtl/display_sequencer.sv
// Power/pay/delay sequencer for the seven-segment display path.
// Optional blink generator enabled by defining DISPLAY_SEQ_FLICKER_EN.
module display_sequencer
   import display_seq_pkg::*;
#(
   parameter int SCAN_DIV     = 50000,
   parameter int FLICKER_DIV  = 8,
   parameter int PAY_FRAMES   = 400,
   parameter int DELAY_FRAMES = 200
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              power_in,
   input  logic              pay_req,
   output logic              power,
   output logic              need_pay,
   output logic              delay,
   output logic              flicker_clk,
   output logic [SCAN_W-1:0] scan_cnt,
   output logic              frame_tick
);

   localparam int TMR_MAX = (PAY_FRAMES > DELAY_FRAMES) ? PAY_FRAMES : DELAY_FRAMES;
   localparam int TMR_W   = clog2_min1(TMR_MAX);
   localparam logic [TMR_W-1:0] PAY_LAST   = TMR_W'(PAY_FRAMES - 1);
   localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(DELAY_FRAMES - 1);

   disp_state_t      state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic             power_q, need_pay_q, delay_q;
   logic             run;

   // Dropping power clears the scan counters on the same edge as the FSM.
   assign run = (state_q != OFF) && power_in;

   scan_prescaler #(
      .SCAN_DIV(SCAN_DIV)
   ) u_scan (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .scan_cnt  (scan_cnt),
      .frame_tick(frame_tick)
   );

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      if (!power_in) begin
         state_d = OFF;
         tmr_d   = '0;
      end else begin
         case (state_q)
            OFF: begin
               state_d = ON;
               tmr_d   = '0;
            end
            ON: begin
               if (pay_req) begin
                  state_d = PAY;
                  tmr_d   = '0;
               end
            end
            PAY: begin
               if (pay_req) begin
                  tmr_d = '0;
               end else if (frame_tick) begin
                  if (tmr_q == PAY_LAST) begin
                     state_d = DELAY;
                     tmr_d   = '0;
                  end else begin
                     tmr_d = tmr_q + TMR_W'(1);
                  end
               end
            end
            DELAY: begin
               if (pay_req) begin
                  state_d = PAY;
                  tmr_d   = '0;
               end else if (frame_tick) begin
                  if (tmr_q == DELAY_LAST) begin
                     state_d = ON;
                     tmr_d   = '0;
                  end else begin
                     tmr_d = tmr_q + TMR_W'(1);
                  end
               end
            end
            default: begin
               state_d = OFF;
               tmr_d   = '0;
            end
         endcase
      end
   end

   // Outputs are registered decodes of the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= OFF;
         tmr_q      <= '0;
         power_q    <= 1'b0;
         need_pay_q <= 1'b0;
         delay_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         tmr_q      <= tmr_d;
         power_q    <= (state_d != OFF);
         need_pay_q <= (state_d == PAY);
         delay_q    <= (state_d == DELAY);
      end
   end

   assign power    = power_q;
   assign need_pay = need_pay_q;
   assign delay    = delay_q;

`ifdef DISPLAY_SEQ_FLICKER_EN
   localparam int FL_W = clog2_min1(FLICKER_DIV);
   localparam logic [FL_W-1:0] FL_LAST = FL_W'(FLICKER_DIV - 1);

   logic [FL_W-1:0] fl_cnt_q, fl_cnt_d;
   logic            flick_q, flick_d;
   logic            pay_entry;

   // Entering PAY restarts the blink phase so the first half-period is dark.
   assign pay_entry = (state_d == PAY) && (state_q != PAY);

   always_comb begin
      fl_cnt_d = fl_cnt_q;
      flick_d  = flick_q;
      if (!power_in || (state_q == OFF) || pay_entry) begin
         fl_cnt_d = '0;
         flick_d  = 1'b0;
      end else if (frame_tick) begin
         if (fl_cnt_q == FL_LAST) begin
            fl_cnt_d = '0;
            flick_d  = ~flick_q;
         end else begin
            fl_cnt_d = fl_cnt_q + FL_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fl_cnt_q <= '0;
         flick_q  <= 1'b0;
      end else begin
         fl_cnt_q <= fl_cnt_d;
         flick_q  <= flick_d;
      end
   end

   assign flicker_clk = flick_q;
`else
   assign flicker_clk = 1'b0;
`endif

endmodule

// File: tb/tb_display_sequencer.sv
// Self-checking bench for display_sequencer: cycle scoreboard plus scenario table.
module tb_display_sequencer;

   localparam int SD    = 4;
   localparam int FD    = 2;
   localparam int PF    = 3;
   localparam int DF    = 2;
   localparam int FRAME = 8 * SD;
   localparam int WIN   = 400;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       power_in = 1'b0;
   logic       pay_req = 1'b0;
   logic       power, need_pay, delay, flicker_clk, frame_tick;
   logic [2:0] scan_cnt;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   display_sequencer #(
      .SCAN_DIV    (SD),
      .FLICKER_DIV (FD),
      .PAY_FRAMES  (PF),
      .DELAY_FRAMES(DF)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .power_in   (power_in),
      .pay_req    (pay_req),
      .power      (power),
      .need_pay   (need_pay),
      .delay      (delay),
      .flicker_clk(flicker_clk),
      .scan_cnt   (scan_cnt),
      .frame_tick (frame_tick)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] outs();
      return {24'b0, power, need_pay, delay, flicker_clk, scan_cnt, frame_tick};
   endfunction

   // Reference model: scan position from elapsed cycles, pay/delay as frames remaining.
   bit  m_on;
   int  m_t;
   int  m_state;
   int  m_left;
   int  m_fticks;
   logic [7:0] sb_q[$];

   function automatic logic [7:0] model_out();
      logic       fl;
      logic [2:0] sc;
      logic       ft;
`ifdef DISPLAY_SEQ_FLICKER_EN
      fl = ((m_fticks / FD) % 2) == 1;
`else
      fl = 1'b0;
`endif
      sc = m_on ? 3'((m_t / SD) % 8) : 3'd0;
      ft = m_on && ((m_t % FRAME) == FRAME - 1);
      return {m_state != 0, m_state == 2, m_state == 3, fl, sc, ft};
   endfunction

   always @(posedge clk) begin : model
      bit tick;
      tick = m_on && ((m_t % FRAME) == FRAME - 1);
      if (rst || !power_in) begin
         m_on = 1'b0; m_t = 0; m_state = 0; m_left = 0; m_fticks = 0;
      end else if (!m_on) begin
         m_on = 1'b1; m_t = 0; m_state = 1; m_fticks = 0;
      end else begin
         m_t++;
         if (tick) m_fticks++;
         case (m_state)
            1: if (pay_req) begin m_state = 2; m_left = PF; m_fticks = 0; end
            2: if (pay_req) m_left = PF;
               else if (tick) begin
                  m_left--;
                  if (m_left == 0) begin m_state = 3; m_left = DF; end
               end
            3: if (pay_req) begin m_state = 2; m_left = PF; m_fticks = 0; end
               else if (tick) begin
                  m_left--;
                  if (m_left == 0) m_state = 1;
               end
            default: m_state = 0;
         endcase
      end
      sb_q.push_back(model_out());
   end

   always @(negedge clk) begin : monitor
      logic [7:0] e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk("cycle_outputs", outs(), {24'b0, e});
      end
   end

   typedef struct {
      string name;
      int    r1;
      int    r2;
      int    exp_pay;
      int    exp_dly;
   } scen_t;

   scen_t tbl[7];

   task automatic power_on();
      @(negedge clk);
      rst = 1'b1; power_in = 1'b0; pay_req = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0; power_in = 1'b1;
      @(posedge clk);
   endtask

   task automatic run_scen(input scen_t s);
      int np = 0;
      int dl = 0;
      power_on();
      for (int k = 0; k < WIN; k++) begin
         @(negedge clk);
         if (need_pay === 1'b1) np++;
         if (delay === 1'b1) dl++;
         pay_req = (k == s.r1) || (k == s.r2);
         @(posedge clk);
      end
      @(negedge clk);
      pay_req = 1'b0;
      chk({s.name, "_pay_cycles"}, np, s.exp_pay);
      chk({s.name, "_delay_cycles"}, dl, s.exp_dly);
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [31:0] acc;
      // Cycle counts below are relative to the first ON cycle; ticks at 31, 63, 95, ...
      tbl[0] = '{"clean",          40,  -1,  87,  64};
      tbl[1] = '{"req_on_tick",    63,  -1,  96,  64};
      tbl[2] = '{"req_before_tick",62,  -1,  65,  64};
      tbl[3] = '{"rereq_pay",      40,  72, 119,  64};
      tbl[4] = '{"req_in_delay",   40, 140, 170,  77};
      tbl[5] = '{"req_pay_expiry", 40, 127, 183,  64};
      tbl[6] = '{"req_dly_expiry", 40, 191, 183, 128};

      // Reset and idle with power off; a pay request in OFF is ignored.
      rst = 1'b1; power_in = 1'b0; pay_req = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("reset_outputs", outs(), 32'd0);
      acc = '0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         acc = acc | outs();
         pay_req = (k == 20);
      end
      pay_req = 1'b0;
      chk("idle_outputs", acc, 32'd0);

      // Scan timing after power-up.
      power_in = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("power_up", 32'(power), 32'd1);
      chk("scan_first", 32'(scan_cnt), 32'd0);
      repeat (3) @(negedge clk);
      chk("scan_slot0_end", 32'(scan_cnt), 32'd0);
      @(negedge clk);
      chk("scan_step1", 32'(scan_cnt), 32'd1);
      repeat (24) @(negedge clk);
      chk("scan_reach7", 32'(scan_cnt), 32'd7);
      repeat (2) @(negedge clk);
      chk("ftick_before", 32'(frame_tick), 32'd0);
      @(negedge clk);
      chk("ftick_first", 32'(frame_tick), 32'd1);
      @(negedge clk);
      chk("ftick_after", 32'(frame_tick), 32'd0);
      chk("scan_wrap", 32'(scan_cnt), 32'd0);
      repeat (31) @(negedge clk);
      chk("ftick_second", 32'(frame_tick), 32'd1);

      for (int i = 0; i < 7; i++) run_scen(tbl[i]);

      // Pay request in DELAY, then power drop mid-PAY.
      power_on();
      for (int k = 0; k <= 160; k++) begin
         @(negedge clk);
         if (k == 140) chk("delay_before_req", 32'(delay), 32'd1);
         if (k == 141) begin
            chk("req_delay_need_pay", 32'(need_pay), 32'd1);
            chk("req_delay_delay", 32'(delay), 32'd0);
         end
         pay_req = (k == 40) || (k == 140);
      end
      chk("pay_before_drop", 32'(need_pay), 32'd1);
      power_in = 1'b0;
      @(negedge clk);
      chk("power_drop", outs(), 32'd0);
      @(negedge clk);
      chk("power_drop_hold", outs(), 32'd0);

      // Reset asserted in DELAY.
      power_on();
      for (int k = 0; k <= 150; k++) begin
         @(negedge clk);
         pay_req = (k == 40);
      end
      chk("delay_before_rst", 32'(delay), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_in_delay", outs(), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("restart_power", 32'(power), 32'd1);
      chk("restart_scan", 32'(scan_cnt), 32'd0);
      repeat (5) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
